hazard_ctrl: RTL and testbench

- Parametrised successor of the combinational instruction classifier.
- Decodes the D-stage instruction into Tuse and Tnew classes.
- Tracks destination register and remaining Tnew for each downstream stage in an internal shift pipeline, and raises the pipeline stall.
- Models multiply/divide occupancy with a cycle counter; sits beside the D/E pipeline registers in the MIPS core.

---
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : hazard_ctrl
// Purpose  : D-stage hazard unit. Tuse/Tnew decode, per-stage destination
//            tracking, md occupancy counter and combinational stall.
//            Optional macro ERET_HAZARD_EN adds the mtc0 EPC -> eret interlock.
// Revision : 1.0 - initial release
//============================================================================
module hazard_ctrl #(
  parameter int NSTAGE      = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        flush,
  output logic        stall,
  output logic        md_busy,
  output logic [2:0]  stall_cause
);

  localparam logic [5:0]       c_op_special = 6'h00;
  localparam logic [5:0]       c_op_cop0    = 6'h10;
  localparam logic [CNT_W-1:0] c_mult_load  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_load   = CNT_W'(DIV_CYCLES);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_rtype;

  assign w_op    = instr_d[31:26];
  assign w_rs    = instr_d[25:21];
  assign w_rt    = instr_d[20:16];
  assign w_rd    = instr_d[15:11];
  assign w_fn    = instr_d[5:0];
  assign w_rtype = (w_op == c_op_special) && (instr_d[10:6] == 5'd0);

  logic w_cal_r, w_cal_i, w_load, w_store, w_br, w_jr, w_jalr, w_jal;
  logic w_md_mul, w_md_div, w_mfhl, w_mthl, w_mtc0, w_mfc0;

  always_comb begin
    w_cal_r  = w_rtype && (w_fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                        6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b});
    w_jr     = w_rtype && (w_fn == 6'h08);
    w_jalr   = w_rtype && (w_fn == 6'h09);
    w_md_mul = w_rtype && (w_fn inside {6'h18, 6'h19});
    w_md_div = w_rtype && (w_fn inside {6'h1a, 6'h1b});
    w_mfhl   = w_rtype && (w_fn inside {6'h10, 6'h12});
    w_mthl   = w_rtype && (w_fn inside {6'h11, 6'h13});
    w_cal_i  = w_op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    w_load   = w_op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    w_store  = w_op inside {6'h28, 6'h29, 6'h2b};
    w_br     = w_op inside {6'h04, 6'h05};
    w_jal    = (w_op == 6'h03);
    w_mtc0   = (w_op == c_op_cop0) && (w_rs == 5'h04) && (instr_d[10:0] == 11'd0);
    w_mfc0   = (w_op == c_op_cop0) && (w_rs == 5'h00) && (instr_d[10:0] == 11'd0);
  end

  // Tuse of each source and the record this instruction would place in E
  logic       w_use_rs, w_use_rt, w_d_vld;
  logic [1:0] w_tuse_rs, w_tuse_rt, w_d_tnew;
  logic [4:0] w_d_dst;

  always_comb begin
    w_use_rs  = 1'b0;
    w_tuse_rs = 2'd0;
    w_use_rt  = 1'b0;
    w_tuse_rt = 2'd0;
    w_d_vld   = 1'b0;
    w_d_dst   = 5'd0;
    w_d_tnew  = 2'd0;
    if (w_br || w_jr || w_jalr) begin
      w_use_rs = 1'b1;
    end else if (w_cal_r || w_cal_i || w_load || w_store || w_md_mul || w_md_div || w_mthl) begin
      w_use_rs  = 1'b1;
      w_tuse_rs = 2'd1;
    end
    if (w_br) begin
      w_use_rt = 1'b1;
    end else if (w_cal_r || w_md_mul || w_md_div) begin
      w_use_rt  = 1'b1;
      w_tuse_rt = 2'd1;
    end else if (w_store || w_mtc0) begin
      w_use_rt  = 1'b1;
      w_tuse_rt = 2'd2;
    end
    if (w_cal_r || w_mfhl) begin
      w_d_vld = 1'b1; w_d_dst = w_rd; w_d_tnew = 2'd1;
    end else if (w_cal_i) begin
      w_d_vld = 1'b1; w_d_dst = w_rt; w_d_tnew = 2'd1;
    end else if (w_load || w_mfc0) begin
      w_d_vld = 1'b1; w_d_dst = w_rt; w_d_tnew = 2'd2;
    end else if (w_jal) begin
      w_d_vld = 1'b1; w_d_dst = 5'd31;
    end else if (w_jalr) begin
      w_d_vld = 1'b1; w_d_dst = w_rd;
    end
  end

  logic [NSTAGE-1:0] r_vld;
  logic [4:0]        r_dst  [NSTAGE];
  logic [1:0]        r_tnew [NSTAGE];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[NSTAGE-2:0], w_d_vld & ~stall};
    end
  end

  // Payload shifts unconditionally; validity alone decides whether it matters
  always_ff @(posedge clk) begin
    r_dst[0]  <= w_d_dst;
    r_tnew[0] <= w_d_tnew;
    for (int k = 1; k < NSTAGE; k++) begin
      r_dst[k]  <= r_dst[k-1];
      r_tnew[k] <= (r_tnew[k-1] != 2'd0) ? (r_tnew[k-1] - 2'd1) : 2'd0;
    end
  end

  logic w_hz_data, w_hz_md, w_hz_eret;

  always_comb begin
    w_hz_data = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (r_vld[k] && (r_dst[k] != 5'd0)) begin
        if (w_use_rs && (r_dst[k] == w_rs) && (r_tnew[k] > w_tuse_rs)) w_hz_data = 1'b1;
        if (w_use_rt && (r_dst[k] == w_rt) && (r_tnew[k] > w_tuse_rt)) w_hz_data = 1'b1;
      end
    end
  end

`ifdef ERET_HAZARD_EN
  // mtc0 writes no GPR, so the EPC flag carries its own occupancy bit
  logic              w_eret, w_d_epc;
  logic [NSTAGE-1:0] r_epc;

  assign w_eret  = (instr_d == 32'h4200_0018);
  assign w_d_epc = w_mtc0 && (w_rd == 5'd14);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_epc <= '0;
    end else begin
      r_epc <= {r_epc[NSTAGE-2:0], w_d_epc & ~stall};
    end
  end

  assign w_hz_eret = w_eret && (|r_epc);
`else
  assign w_hz_eret = 1'b0;
`endif

  logic [CNT_W-1:0] r_cnt;
  logic             w_md_start;

  assign w_md_start = (w_md_mul || w_md_div) && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_md_start) begin
      r_cnt <= w_md_div ? c_div_load : c_mult_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign md_busy     = (r_cnt != '0);
  assign w_hz_md     = (w_md_mul || w_md_div || w_mfhl || w_mthl) && md_busy;
  assign stall_cause = {w_hz_eret, w_hz_md, w_hz_data};
  assign stall       = |stall_cause;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard bench for hazard_ctrl with an instruction-level model.
// Revision : 1.0 - initial release
//============================================================================
module tb_hazard_ctrl;

  localparam int NSTAGE      = 3;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;
  localparam int N_CYC       = 2000;
`ifdef ERET_HAZARD_EN
  localparam bit ERET_EN = 1'b1;
`else
  localparam bit ERET_EN = 1'b0;
`endif

  localparam int K_NOP = 0,  K_J = 1,     K_ADDU = 2,  K_SUBU = 3,  K_AND = 4,  K_OR = 5;
  localparam int K_SLT = 6,  K_ADDIU = 7, K_ORI = 8,   K_LUI = 9,   K_LW = 10,  K_LB = 11;
  localparam int K_SW = 12,  K_SB = 13,   K_BEQ = 14,  K_BNE = 15,  K_JR = 16,  K_JALR = 17;
  localparam int K_JAL = 18, K_MTC0 = 19, K_MFC0 = 20, K_ERET = 21, K_MULT = 22, K_MULTU = 23;
  localparam int K_DIV = 24, K_DIVU = 25, K_MFHI = 26, K_MFLO = 27, K_MTHI = 28, K_MTLO = 29;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [31:0] instr_d;
  logic        stall, md_busy;
  logic [2:0]  stall_cause;

  hazard_ctrl #(
    .NSTAGE(NSTAGE), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .flush(flush),
    .stall(stall), .md_busy(md_busy), .stall_cause(stall_cause)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; bit fl; bit rst; } entry_t;
  typedef struct { bit use_rs; int tuse_rs; bit use_rt; int tuse_rt; int dst_sel; int tnew;
                   bit md_any; int md_len; bit eret; } prop_t;
  typedef struct { int age; logic [4:0] dst; int tnew0; bit has_dst; bit epc; } rec_t;
  typedef struct packed { logic stall; logic md_busy; logic [2:0] cause; } exp_t;

  rec_t   inflight[$];
  exp_t   exp_q[$];
  entry_t prog[$];
  int     md_until = -1;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic logic [31:0] enc(entry_t e);
    case (e.kind)
      K_ADDU:  return {6'h00, e.rs, e.rt, e.rd, 5'd0, 6'h21};
      K_SUBU:  return {6'h00, e.rs, e.rt, e.rd, 5'd0, 6'h23};
      K_AND:   return {6'h00, e.rs, e.rt, e.rd, 5'd0, 6'h24};
      K_OR:    return {6'h00, e.rs, e.rt, e.rd, 5'd0, 6'h25};
      K_SLT:   return {6'h00, e.rs, e.rt, e.rd, 5'd0, 6'h2a};
      K_ADDIU: return {6'h09, e.rs, e.rt, 16'h0004};
      K_ORI:   return {6'h0d, e.rs, e.rt, 16'h00f0};
      K_LUI:   return {6'h0f, e.rs, e.rt, 16'h1234};
      K_LW:    return {6'h23, e.rs, e.rt, 16'h0008};
      K_LB:    return {6'h20, e.rs, e.rt, 16'h0001};
      K_SW:    return {6'h2b, e.rs, e.rt, 16'h0008};
      K_SB:    return {6'h28, e.rs, e.rt, 16'h0002};
      K_BEQ:   return {6'h04, e.rs, e.rt, 16'h0010};
      K_BNE:   return {6'h05, e.rs, e.rt, 16'hfff0};
      K_JR:    return {6'h00, e.rs, 15'd0, 6'h08};
      K_JALR:  return {6'h00, e.rs, 5'd0, e.rd, 5'd0, 6'h09};
      K_JAL:   return {6'h03, 26'h0000040};
      K_J:     return {6'h02, 26'h0000040};
      K_MULT:  return {6'h00, e.rs, e.rt, 10'd0, 6'h18};
      K_MULTU: return {6'h00, e.rs, e.rt, 10'd0, 6'h19};
      K_DIV:   return {6'h00, e.rs, e.rt, 10'd0, 6'h1a};
      K_DIVU:  return {6'h00, e.rs, e.rt, 10'd0, 6'h1b};
      K_MFHI:  return {6'h00, 10'd0, e.rd, 5'd0, 6'h10};
      K_MFLO:  return {6'h00, 10'd0, e.rd, 5'd0, 6'h12};
      K_MTHI:  return {6'h00, e.rs, 15'd0, 6'h11};
      K_MTLO:  return {6'h00, e.rs, 15'd0, 6'h13};
      K_MTC0:  return {6'h10, 5'h04, e.rt, e.rd, 11'd0};
      K_MFC0:  return {6'h10, 5'h00, e.rt, e.rd, 11'd0};
      K_ERET:  return 32'h4200_0018;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Instruction-level rules: dst_sel 1=rd, 2=rt, 3=$31
  function automatic prop_t props(int k);
    prop_t p;
    p = '{default: 0};
    case (k)
      K_ADDU, K_SUBU, K_AND, K_OR, K_SLT: begin
        p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 1; p.dst_sel = 1; p.tnew = 1;
      end
      K_ADDIU, K_ORI, K_LUI: begin p.use_rs = 1; p.tuse_rs = 1; p.dst_sel = 2; p.tnew = 1; end
      K_LW, K_LB:            begin p.use_rs = 1; p.tuse_rs = 1; p.dst_sel = 2; p.tnew = 2; end
      K_SW, K_SB:            begin p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 2; end
      K_BEQ, K_BNE:          begin p.use_rs = 1; p.use_rt = 1; end
      K_JR:                  p.use_rs = 1;
      K_JALR:                begin p.use_rs = 1; p.dst_sel = 1; end
      K_JAL:                 p.dst_sel = 3;
      K_MULT, K_MULTU: begin
        p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 1; p.md_any = 1; p.md_len = MULT_CYCLES;
      end
      K_DIV, K_DIVU: begin
        p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 1; p.md_any = 1; p.md_len = DIV_CYCLES;
      end
      K_MFHI, K_MFLO:        begin p.md_any = 1; p.dst_sel = 1; p.tnew = 1; end
      K_MTHI, K_MTLO:        begin p.md_any = 1; p.use_rs = 1; p.tuse_rs = 1; end
      K_MTC0:                begin p.use_rt = 1; p.tuse_rt = 2; end
      K_MFC0:                begin p.dst_sel = 2; p.tnew = 2; end
      K_ERET:                p.eret = 1;
      default: ;
    endcase
    return p;
  endfunction

  function automatic exp_t model_eval(entry_t e);
    prop_t p;
    exp_t  x;
    bit    dh, eh, busy;
    int    tn;
    p  = props(e.kind);
    dh = 0;
    eh = 0;
    foreach (inflight[i]) begin
      tn = inflight[i].tnew0 - inflight[i].age;
      if (tn < 0) tn = 0;
      if (inflight[i].has_dst && inflight[i].dst != 5'd0) begin
        if (p.use_rs && inflight[i].dst == e.rs && tn > p.tuse_rs) dh = 1;
        if (p.use_rt && inflight[i].dst == e.rt && tn > p.tuse_rt) dh = 1;
      end
      if (inflight[i].epc && p.eret && ERET_EN) eh = 1;
    end
    busy      = (cyc <= md_until);
    x.cause   = {eh, p.md_any && busy, dh};
    x.stall   = |x.cause;
    x.md_busy = busy;
    return x;
  endfunction

  // Advance the model across one clock edge
  task automatic model_step(entry_t e, bit fl, bit rst, bit st);
    prop_t p;
    rec_t  keep[$];
    rec_t  r;
    p = props(e.kind);
    if (rst) begin
      inflight.delete();
      md_until = -1;
    end else begin
      if (p.md_len != 0 && !st && !fl) md_until = cyc + p.md_len;
      if (fl) begin
        inflight.delete();
      end else begin
        foreach (inflight[i]) begin
          r = inflight[i];
          r.age++;
          if (r.age < NSTAGE) keep.push_back(r);
        end
        inflight = keep;
        r.age     = 0;
        r.has_dst = (p.dst_sel != 0);
        r.dst     = (p.dst_sel == 1) ? e.rd : (p.dst_sel == 2) ? e.rt : 5'd31;
        r.tnew0   = p.tnew;
        r.epc     = (e.kind == K_MTC0) && (e.rd == 5'd14);
        if (!st && (r.has_dst || r.epc)) inflight.push_front(r);
      end
    end
    cyc++;
  endtask

  function automatic logic [4:0] rreg();
    int v;
    v = $urandom_range(0, 5);
    return (v == 5) ? 5'd31 : 5'(v);
  endfunction

  function automatic entry_t rand_entry();
    entry_t e;
    e.kind = ($urandom_range(0, 99) < 10) ? $urandom_range(K_MULT, K_MTLO) : $urandom_range(K_NOP, K_ERET);
    e.rs   = rreg();
    e.rt   = rreg();
    e.rd   = (e.kind == K_MTC0) ? (($urandom_range(0, 1) == 1) ? 5'd14 : 5'd12) : rreg();
    e.fl   = ($urandom_range(0, 39) == 0);
    e.rst  = ($urandom_range(0, 149) == 0);
    return e;
  endfunction

  task automatic add(int k, int rs, int rt, int rd, bit fl = 0, bit rst = 0);
    entry_t e;
    e.kind = k; e.rs = 5'(rs); e.rt = 5'(rt); e.rd = 5'(rd); e.fl = fl; e.rst = rst;
    prog.push_back(e);
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) add(K_NOP, 0, 0, 0);
  endtask

  initial begin : stim
    entry_t cur;
    exp_t   x;
    bit     hold;
    reset = 1'b1; flush = 1'b0; instr_d = 32'h0; hold = 1'b0;
    cur = '{kind: K_NOP, rs: 5'd0, rt: 5'd0, rd: 5'd0, fl: 1'b0, rst: 1'b0};
    add(K_ADDU, 1, 2, 3, 0, 1); add(K_MFLO, 0, 0, 6, 0, 1); add(K_ERET, 0, 0, 0, 0, 1);
    add(K_LW, 0, 1, 0); add(K_ADDU, 1, 3, 2); nops(3);
    add(K_LW, 0, 1, 0); add(K_BEQ, 1, 2, 0); nops(3);
    add(K_ADDU, 4, 5, 0); add(K_SUBU, 0, 0, 6); nops(2);
    add(K_LW, 0, 1, 0); nops(2); add(K_ADDU, 1, 1, 2); nops(2);
    add(K_JAL, 0, 0, 0); add(K_JR, 31, 0, 0); nops(2);
    add(K_DIV, 4, 5, 0); add(K_MFLO, 0, 0, 6); nops(2);
    add(K_MULT, 4, 5, 0); add(K_MFHI, 0, 0, 7); nops(2);
    add(K_MTC0, 0, 7, 14); add(K_ERET, 0, 0, 0); nops(4);
    add(K_LW, 0, 1, 0); add(K_ADDU, 1, 3, 2, 1, 0); nops(3);
    add(K_DIV, 4, 5, 0); add(K_MFLO, 0, 0, 6, 0, 1); nops(2);
    repeat (2) @(posedge clk);
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        cur   = (prog.size() > 0) ? prog.pop_front() : rand_entry();
        flush = cur.fl;
        reset = cur.rst;
      end else begin
        flush = (prog.size() == 0) && ($urandom_range(0, 39) == 0);
        reset = 1'b0;
      end
      instr_d = enc(cur);
      x = model_eval(cur);
      exp_q.push_back(x);
      model_step(cur, flush, reset, x.stall);
      hold = x.stall;
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected responses never checked (required 0)", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (stall !== e.stall) begin
          n_errors++;
          $display("FAIL stall t=%0t instr=%h got=%b exp=%b", $time, instr_d, stall, e.stall);
        end
        n_checks++;
        if (stall_cause !== e.cause) begin
          n_errors++;
          $display("FAIL stall_cause t=%0t instr=%h got=%b exp=%b", $time, instr_d, stall_cause, e.cause);
        end
        n_checks++;
        if (md_busy !== e.md_busy) begin
          n_errors++;
          $display("FAIL md_busy t=%0t instr=%h got=%b exp=%b", $time, instr_d, md_busy, e.md_busy);
        end
      end
    end
  end

endmodule
`default_nettype wire
